// File: rtl/stack_cmd_driver_pkg.sv
// Shared definitions for the stack_cpu command driver: opcode values and
// driver FSM states.
package stack_cmd_driver_pkg;

    localparam logic [3:0] OP_NOOP = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_POP  = 4'h2;
    localparam logic [3:0] OP_OUTL = 4'h3;
    localparam logic [3:0] OP_OUTH = 4'h4;
    localparam logic [3:0] OP_SWAP = 4'h5;
    localparam logic [3:0] OP_PUSF = 4'h6;
    localparam logic [3:0] OP_REPL = 4'h7;
    localparam logic [3:0] OP_BINA = 4'h8;
    localparam logic [3:0] OP_MULT = 4'h9;
    localparam logic [3:0] OP_IDIV = 4'hA;
    localparam logic [3:0] OP_CLFL = 4'hB;

    typedef enum logic [2:0] {
        DRV_RESET,
        DRV_IDLE,
        DRV_FETCH,
        DRV_EXEC,
        DRV_SAMPLE
    } drv_state_t;

endpackage

// File: rtl/stack_cmd_driver_op_timing.sv
// Number of execution cycles stack_cpu spends on each opcode after fetch.
module stack_op_timing
    import stack_cmd_driver_pkg::*;
(
    input  logic [3:0] op,
    output logic [1:0] exec_len
);

    always_comb begin
        case (op)
            OP_PUSH, OP_POP, OP_SWAP, OP_PUSF, OP_REPL, OP_BINA: exec_len = 2'd2;
            OP_MULT, OP_IDIV:                                    exec_len = 2'd3;
            default:                                             exec_len = 2'd1;
        endcase
    end

endmodule

// File: rtl/stack_cmd_driver.sv
// Host-side initiator for stack_cpu: serialises {op, arg, mode, read} commands
// into the CPU's inbits nibble stream and optionally captures its output byte.
module stack_cmd_driver
    import stack_cmd_driver_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_arg,
    input  logic [1:0] cmd_mode,
    input  logic       cmd_read,
    input  logic       cmd_init,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       cpu_rst,
    output logic [3:0] cpu_inbits,
    output logic [1:0] cpu_output_mode,
    input  logic [7:0] cpu_io_out
);

    localparam logic [3:0] RST_INIT = 4'(RESET_CYCLES - 1);

    drv_state_t state, state_nxt;
    logic [3:0] rst_cnt, rst_cnt_nxt;
    logic [1:0] exec_cnt, exec_cnt_nxt;
    logic       cpu_fetch, cpu_fetch_nxt;
    logic [3:0] op_q, arg_q;
    logic       read_q;
    logic [1:0] exec_len;
    logic       accept;

    logic       cpu_rst_nxt, busy_nxt, rsp_valid_nxt;
    logic [3:0] inbits_nxt;
    logic [1:0] mode_nxt;
    logic [7:0] rsp_data_nxt;

    stack_op_timing u_timing (
        .op       (op_q),
        .exec_len (exec_len)
    );

    // cpu_fetch tracks the CPU's own fetch/exec alternation while it runs NOOPs
    assign cmd_ready = (state == DRV_IDLE) && !cpu_fetch;
    assign accept    = cmd_valid && cmd_ready && !cmd_init;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= DRV_RESET;
            rst_cnt         <= RST_INIT;
            exec_cnt        <= '0;
            cpu_fetch       <= 1'b0;
            op_q            <= '0;
            arg_q           <= '0;
            read_q          <= 1'b0;
            cpu_rst         <= 1'b1;
            cpu_inbits      <= '0;
            cpu_output_mode <= '0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            busy            <= 1'b1;
        end else begin
            state           <= state_nxt;
            rst_cnt         <= rst_cnt_nxt;
            exec_cnt        <= exec_cnt_nxt;
            cpu_fetch       <= cpu_fetch_nxt;
            cpu_rst         <= cpu_rst_nxt;
            cpu_inbits      <= inbits_nxt;
            cpu_output_mode <= mode_nxt;
            rsp_valid       <= rsp_valid_nxt;
            rsp_data        <= rsp_data_nxt;
            busy            <= busy_nxt;
            if (accept) begin
                op_q   <= cmd_op;
                arg_q  <= cmd_arg;
                read_q <= cmd_read;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        rst_cnt_nxt   = rst_cnt;
        exec_cnt_nxt  = exec_cnt;
        cpu_fetch_nxt = cpu_fetch;
        case (state)
            DRV_RESET: begin
                if (rst_cnt == '0) begin
                    state_nxt     = DRV_IDLE;
                    cpu_fetch_nxt = 1'b1;
                end else begin
                    rst_cnt_nxt = rst_cnt - 4'd1;
                end
            end
            DRV_IDLE: begin
                cpu_fetch_nxt = !cpu_fetch;
                if (cmd_init) begin
                    state_nxt   = DRV_RESET;
                    rst_cnt_nxt = RST_INIT;
                end else if (accept) begin
                    state_nxt = DRV_FETCH;
                end
            end
            DRV_FETCH: begin
                state_nxt    = DRV_EXEC;
                exec_cnt_nxt = exec_len - 2'd1;
            end
            DRV_EXEC: begin
                if (exec_cnt == '0) begin
                    if (read_q) begin
                        state_nxt = DRV_SAMPLE;
                    end else begin
                        state_nxt     = DRV_IDLE;
                        cpu_fetch_nxt = 1'b1;
                    end
                end else begin
                    exec_cnt_nxt = exec_cnt - 2'd1;
                end
            end
            DRV_SAMPLE: begin
                state_nxt     = DRV_IDLE;
                cpu_fetch_nxt = 1'b0;
            end
            default: begin
                state_nxt   = DRV_RESET;
                rst_cnt_nxt = RST_INIT;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the upcoming state
    always_comb begin
        cpu_rst_nxt   = (state_nxt == DRV_RESET);
        busy_nxt      = (state_nxt != DRV_IDLE);
        mode_nxt      = accept ? cmd_mode : cpu_output_mode;
        rsp_valid_nxt = (state == DRV_SAMPLE);
        rsp_data_nxt  = (state == DRV_SAMPLE) ? cpu_io_out : rsp_data;
        if (accept) begin
            inbits_nxt = cmd_op;
        end else if (state_nxt == DRV_EXEC) begin
            inbits_nxt = arg_q;
        end else begin
            inbits_nxt = '0;
        end
    end

endmodule

// File: tb/tb_stack_cmd_driver.sv
// Directed bench for stack_cmd_driver; cpu_io_out is driven with hand-computed
// CPU results only during the cycle the driver is expected to capture it.
module tb_stack_cmd_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_read, cmd_init;
    logic [3:0] cmd_op, cmd_arg;
    logic [1:0] cmd_mode;
    logic       rsp_valid, busy, cpu_rst;
    logic [7:0] rsp_data, cpu_io_out;
    logic [3:0] cpu_inbits;
    logic [1:0] cpu_output_mode;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    stack_cmd_driver #(.RESET_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_arg         (cmd_arg),
        .cmd_mode        (cmd_mode),
        .cmd_read        (cmd_read),
        .cmd_init        (cmd_init),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .busy            (busy),
        .cpu_rst         (cpu_rst),
        .cpu_inbits      (cpu_inbits),
        .cpu_output_mode (cpu_output_mode),
        .cpu_io_out      (cpu_io_out)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and check every cycle up to the next cmd_ready.
    // keep: leave cmd_valid and fields asserted; noise: hold cmd_init high mid-command.
    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [3:0] arg,
                           input logic [1:0] mode, input logic rd, input int n,
                           input logic [7:0] rsp, input logic keep, input logic noise);
        int waited = 0;
        cmd_op = op; cmd_arg = arg; cmd_mode = mode; cmd_read = rd; cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && waited < 8) begin
            step();
            waited++;
        end
        chk({tag, " ready_before_accept"}, 8'(cmd_ready), 8'h1);
        step();
        if (!keep) begin
            cmd_valid = 1'b0; cmd_op = ~op; cmd_arg = ~arg; cmd_mode = ~mode; cmd_read = ~rd;
        end
        cmd_init = noise;
        chk({tag, " fetch_inbits"}, 8'(cpu_inbits), 8'(op));
        chk({tag, " fetch_mode"}, 8'(cpu_output_mode), 8'(mode));
        chk({tag, " fetch_busy"}, 8'(busy), 8'h1);
        chk({tag, " fetch_ready"}, 8'(cmd_ready), 8'h0);
        chk({tag, " fetch_rsp_valid"}, 8'(rsp_valid), 8'h0);
        for (int k = 1; k <= n; k++) begin
            step();
            chk({tag, " exec_inbits"}, 8'(cpu_inbits), 8'(arg));
            chk({tag, " exec_ready"}, 8'(cmd_ready), 8'h0);
            chk({tag, " exec_cpu_rst"}, 8'(cpu_rst), 8'h0);
            if (k == n) cmd_init = 1'b0;
        end
        step();
        chk({tag, " post_inbits"}, 8'(cpu_inbits), 8'h0);
        chk({tag, " post_ready"}, 8'(cmd_ready), 8'h0);
        chk({tag, " post_busy"}, 8'(busy), 8'(rd));
        chk({tag, " post_rsp_valid"}, 8'(rsp_valid), 8'h0);
        if (rd) cpu_io_out = rsp;
        step();
        cpu_io_out = 8'hEE;
        chk({tag, " done_ready"}, 8'(cmd_ready), 8'h1);
        chk({tag, " done_busy"}, 8'(busy), 8'h0);
        chk({tag, " done_mode_hold"}, 8'(cpu_output_mode), 8'(mode));
        chk({tag, " done_rsp_valid"}, 8'(rsp_valid), 8'(rd));
        if (rd) chk({tag, " rsp_data"}, rsp_data, rsp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; cmd_mode = '0;
        cmd_read = 1'b0; cmd_init = 1'b0; cpu_io_out = 8'hEE;
        #2;
        chk("rst cpu_rst", 8'(cpu_rst), 8'h1);
        chk("rst busy", 8'(busy), 8'h1);
        chk("rst ready", 8'(cmd_ready), 8'h0);
        chk("rst inbits", 8'(cpu_inbits), 8'h0);
        chk("rst mode", 8'(cpu_output_mode), 8'h0);
        chk("rst rsp_valid", 8'(rsp_valid), 8'h0);
        chk("rst rsp_data", rsp_data, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        step();
        chk("boot1 cpu_rst", 8'(cpu_rst), 8'h1);
        chk("boot1 inbits", 8'(cpu_inbits), 8'h0);
        step();
        chk("boot2 cpu_rst", 8'(cpu_rst), 8'h0);
        chk("boot2 busy", 8'(busy), 8'h0);
        chk("boot2 ready", 8'(cmd_ready), 8'h0);
        chk("boot2 inbits", 8'(cpu_inbits), 8'h0);
        step();
        chk("boot3 ready", 8'(cmd_ready), 8'h1);

        run_cmd("push5", 4'h1, 4'h5, 2'd0, 1'b0, 2, 8'h00, 1'b0, 1'b0);
        run_cmd("outl5", 4'h3, 4'h0, 2'd0, 1'b1, 1, 8'h05, 1'b0, 1'b0);
        step();
        chk("outl5 pulse_end", 8'(rsp_valid), 8'h0);
        chk("outl5 data_hold", rsp_data, 8'h05);

        run_cmd("push7", 4'h1, 4'h7, 2'd1, 1'b0, 2, 8'h00, 1'b0, 1'b1);
        run_cmd("push9", 4'h1, 4'h9, 2'd1, 1'b0, 2, 8'h00, 1'b0, 1'b0);
        run_cmd("mult",  4'h9, 4'h0, 2'd2, 1'b0, 3, 8'h00, 1'b0, 1'b1);
        run_cmd("outh",  4'h4, 4'h0, 2'd2, 1'b0, 1, 8'h00, 1'b0, 1'b0);
        run_cmd("pop",   4'h2, 4'h0, 2'd0, 1'b0, 2, 8'h00, 1'b0, 1'b0);
        run_cmd("outl3f", 4'h3, 4'h0, 2'd0, 1'b1, 1, 8'h3F, 1'b0, 1'b0);

        run_cmd("push5b", 4'h1, 4'h5, 2'd0, 1'b0, 2, 8'h00, 1'b0, 1'b0);
        run_cmd("push0",  4'h1, 4'h0, 2'd0, 1'b0, 2, 8'h00, 1'b0, 1'b0);
        run_cmd("idiv",   4'hA, 4'h0, 2'd0, 1'b0, 3, 8'h00, 1'b0, 1'b0);
        run_cmd("pusf",   4'h6, 4'h2, 2'd0, 1'b0, 2, 8'h00, 1'b0, 1'b0);
        run_cmd("outl_err", 4'h3, 4'h0, 2'd0, 1'b1, 1, 8'h02, 1'b0, 1'b0);
        run_cmd("clfl",   4'hB, 4'h0, 2'd0, 1'b0, 1, 8'h00, 1'b0, 1'b0);
        run_cmd("pusf2",  4'h6, 4'h2, 2'd0, 1'b0, 2, 8'h00, 1'b0, 1'b0);
        run_cmd("outl_clr", 4'h3, 4'h0, 2'd0, 1'b1, 1, 8'h00, 1'b0, 1'b0);

        run_cmd("held_noop", 4'h0, 4'h3, 2'd1, 1'b0, 1, 8'h00, 1'b1, 1'b0);
        run_cmd("held_push", 4'h1, 4'h4, 2'd2, 1'b0, 2, 8'h00, 1'b1, 1'b1);
        run_cmd("held_mult", 4'h9, 4'hC, 2'd3, 1'b0, 3, 8'h00, 1'b1, 1'b0);
        run_cmd("held_opf",  4'hF, 4'h6, 2'd1, 1'b1, 1, 8'hA7, 1'b1, 1'b0);
        cmd_valid = 1'b0;
        step();
        chk("held pulse_end", 8'(rsp_valid), 8'h0);

        begin : async_reset
            int waited = 0;
            cmd_op = 4'h9; cmd_arg = 4'h1; cmd_mode = 2'd2; cmd_read = 1'b1; cmd_valid = 1'b1;
            while (cmd_ready !== 1'b1 && waited < 8) begin
                step();
                waited++;
            end
            chk("arst ready_before_accept", 8'(cmd_ready), 8'h1);
            step();
            cmd_valid = 1'b0;
            step();
            step();
            chk("arst mid_exec_inbits", 8'(cpu_inbits), 8'h1);
            #2 rst = 1'b1;
            #1;
            chk("arst cpu_rst_immediate", 8'(cpu_rst), 8'h1);
            chk("arst busy", 8'(busy), 8'h1);
            chk("arst ready", 8'(cmd_ready), 8'h0);
            chk("arst inbits", 8'(cpu_inbits), 8'h0);
            chk("arst mode", 8'(cpu_output_mode), 8'h0);
            step();
            step();
            chk("arst no_rsp", 8'(rsp_valid), 8'h0);
            @(negedge clk) rst = 1'b0;
            step();
            chk("arst rec1 cpu_rst", 8'(cpu_rst), 8'h1);
            chk("arst rec1 no_rsp", 8'(rsp_valid), 8'h0);
            step();
            chk("arst rec2 cpu_rst", 8'(cpu_rst), 8'h0);
            chk("arst rec2 ready", 8'(cmd_ready), 8'h0);
            chk("arst rec2 no_rsp", 8'(rsp_valid), 8'h0);
            step();
            chk("arst rec3 ready", 8'(cmd_ready), 8'h1);

            cmd_init = 1'b1;
            step();
            cmd_init = 1'b0;
            chk("init1 cpu_rst", 8'(cpu_rst), 8'h1);
            chk("init1 busy", 8'(busy), 8'h1);
            chk("init1 ready", 8'(cmd_ready), 8'h0);
            step();
            chk("init2 cpu_rst", 8'(cpu_rst), 8'h1);
            step();
            chk("init3 cpu_rst", 8'(cpu_rst), 8'h0);
            chk("init3 busy", 8'(busy), 8'h0);
            chk("init3 ready", 8'(cmd_ready), 8'h0);
            step();
            chk("init4 ready", 8'(cmd_ready), 8'h1);
            chk("init4 no_rsp", 8'(rsp_valid), 8'h0);
        end

        run_cmd("final_outl", 4'h3, 4'h0, 2'd3, 1'b1, 1, 8'h5A, 1'b0, 1'b0);
        step();
        chk("final pulse_end", 8'(rsp_valid), 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
